store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports st_valid input 1, st_addr input ADDR_W, st_data input 32, st_mask input 4: store push from MEM stage (word address = st_addr[ADDR_W-1:2], byte enables).
REQ-006 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-007 SHALL have ports ld_valid input 1, ld_addr input ADDR_W: load lookup from MEM stage.
REQ-008 SHALL have ports ld_hit output 1, ld_data output 32, ld_stall output 1: forward result / stall request.
REQ-009 SHALL have ports mem_write_req output 1, mem_addr output ADDR_W, mem_data output 32, mem_mask output 4, mem_ack input 1: drain handshake to data memory.
REQ-010 SHALL have ports count output clog2(DEPTH)+1 (occupied entries), empty output 1.

Function
REQ-011 SHALL hold entries in FIFO order (head = oldest) with head/tail pointers wrapping modulo DEPTH.
REQ-012 SHALL drive st_ready = (count != DEPTH), from registered count only.
REQ-013 SHALL push {addr, data, mask} at the edge where st_valid && st_ready; count updates the following cycle.
REQ-014 SHALL ignore st_valid when st_ready is low (no overwrite, no error flag); the MEM stage stalls.
REQ-015 SHALL implement drain FSM with states IDLE and BUSY.
REQ-016 IDLE: if count != 0 at an edge, SHALL move to BUSY; mem_write_req low in IDLE.
REQ-017 BUSY: SHALL assert mem_write_req with mem_addr/mem_data/mem_mask = head entry, held stable until mem_ack.
REQ-018 BUSY with mem_ack high at an edge: SHALL pop head and return to IDLE (one idle cycle between consecutive drains).
REQ-019 mem_ack while IDLE SHALL be ignored.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and update both pointers.
REQ-021 Load lookup SHALL be combinational over all occupied entries (including head while BUSY), comparing word addresses only.
REQ-022 If ld_valid and youngest matching entry has mask 4'hF: ld_hit=1, ld_data=that entry's data, ld_stall=0.
REQ-023 If ld_valid and any entry matches but youngest match mask != 4'hF: ld_hit=0, ld_stall=1 (held until matching entries drain).
REQ-024 If no match or ld_valid low: ld_hit=0, ld_stall=0, ld_data=0.
REQ-025 A store pushed in the same cycle as a load SHALL NOT be visible to that load.
REQ-026 empty SHALL equal (count == 0).

Reset
REQ-027 RESET high at an edge SHALL clear all entries and pointers: count=0, empty=1, st_ready=1, FSM=IDLE.
REQ-028 After reset: mem_write_req=0, mem_addr=0, mem_data=0, mem_mask=0, ld_hit=0, ld_stall=0.
REQ-029 RESET during BUSY SHALL abandon the pending write (mem_write_req low next cycle); a concurrent mem_ack SHALL be ignored.
REQ-030 RESET SHALL take priority over push, pop and ack in the same cycle.

Verification
REQ-031 Push st_addr=0x100, data=0xDEADBEEF, mask=F; ack 2 cycles after req -> count 1 then 0; mem_addr=0x100, mem_data=0xDEADBEEF held until ack.
REQ-032 Push 0x200/0x11111111/F then 0x200/0x22222222/F; load 0x200 -> ld_hit=1, ld_data=0x22222222.
REQ-033 Push 0x300 mask=4'b0011; load 0x300 -> ld_stall=1 until that entry acked, then ld_stall=0, ld_hit=0.
REQ-034 Push DEPTH stores, mem_ack low -> st_ready=0; extra push ignored; one ack -> st_ready=1 next cycle; drain order matches push order across pointer wrap.
REQ-035 Push + load same address same cycle on empty buffer -> ld_hit=0; next cycle load -> ld_hit=1.
REQ-036 Assert RESET while BUSY with mem_ack=1 -> next cycle count=0, mem_write_req=0, no further writes issued.

Source files
------------

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : FIFO store buffer with drain FSM and load-forwarding lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [31:0]              st_data,
  input  logic [3:0]               st_mask,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [31:0]              ld_data,
  output logic                     ld_stall,
  output logic                     mem_write_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_data,
  output logic [3:0]               mem_mask,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [31:0]       data_q [DEPTH];
  logic [3:0]        mask_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [0:0]        state_q, state_d;

  logic              w_push;
  logic              w_pop;
  logic              w_busy;
  logic              w_hit_any;
  logic [3:0]        w_hit_mask;
  logic [31:0]       w_hit_data;
  logic [PTR_W-1:0]  w_idx;
  logic [1:0]        w_unused_ld_lo;

  assign w_busy   = (state_q == S_BUSY);
  assign st_ready = (count_q != C_FULL);
  assign w_push   = st_valid && st_ready;
  assign w_pop    = w_busy && mem_ack;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (w_push) tail_d = tail_q + PTR_W'(1);
    if (w_pop)  head_d = head_q + PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (state_q == S_IDLE) begin
      if (count_q != '0) state_d = S_BUSY;
    end else begin
      if (mem_ack) state_d = S_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      if (w_push) begin
        addr_q[tail_q] <= st_addr;
        data_q[tail_q] <= st_data;
        mask_q[tail_q] <= st_mask;
      end
    end
  end

  // Walk oldest-to-youngest so the last match left standing is the youngest.
  always_comb begin
    w_hit_any  = 1'b0;
    w_hit_mask = '0;
    w_hit_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) &&
          (addr_q[w_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        w_hit_any  = 1'b1;
        w_hit_mask = mask_q[w_idx];
        w_hit_data = data_q[w_idx];
      end
    end
  end

  assign w_unused_ld_lo = ld_addr[1:0];

  assign ld_hit   = ld_valid && w_hit_any && (w_hit_mask == 4'hF);
  assign ld_stall = ld_valid && w_hit_any && (w_hit_mask != 4'hF);
  assign ld_data  = ld_hit ? w_hit_data : 32'h0;

  assign mem_write_req = w_busy;
  assign mem_addr      = w_busy ? addr_q[head_q] : '0;
  assign mem_data      = w_busy ? data_q[head_q] : 32'h0;
  assign mem_mask      = w_busy ? mask_q[head_q] : 4'h0;

  assign count = count_q;
  assign empty = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Directed self-checking bench for store_buffer with drain scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_t;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              st_valid = 1'b0;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [31:0]       st_data = '0;
  logic [3:0]        st_mask = '0;
  logic              st_ready;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic              ld_hit;
  logic [31:0]       ld_data;
  logic              ld_stall;
  logic              mem_write_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic [3:0]        mem_mask;
  logic              mem_ack = 1'b0;
  logic [2:0]        count;
  logic              empty;

  int  checks = 0;
  int  errors = 0;
  int  mcount = 0;
  sb_t sbq[$];

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_write_req(mem_write_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_mask(mem_mask), .mem_ack(mem_ack),
    .count(count), .empty(empty)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Acceptance is decided from the bench's own occupancy model.
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bit acc;
    acc      = (mcount != DEPTH);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_mask  = m;
    tick();
    st_valid = 1'b0;
    if (acc) begin
      sbq.push_back('{addr: a, data: d, mask: m});
      mcount++;
    end
    chk("push_count", 32'(count), 32'(mcount));
  endtask

  task automatic drain(input int hold, input bit wp, input logic [31:0] pa,
                       input logic [31:0] pd, input logic [3:0] pm);
    int  waited;
    bit  acc;
    sb_t e;
    waited = 0;
    while (mem_write_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("drain_req", 32'(mem_write_req), 32'd1);
    if (mem_write_req === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL drain_unexpected: observed write addr=%h expected no write", mem_addr);
      end else begin
        e = sbq.pop_front();
        for (int h = 0; h <= hold; h++) begin
          if (h > 0) begin
            tick();
            chk("drain_req_held", 32'(mem_write_req), 32'd1);
          end
          chk("drain_addr", mem_addr, e.addr);
          chk("drain_data", mem_data, e.data);
          chk("drain_mask", 32'(mem_mask), 32'(e.mask));
        end
        acc = 1'b0;
        mem_ack = 1'b1;
        if (wp) begin
          acc      = (mcount != DEPTH);
          st_valid = 1'b1;
          st_addr  = pa;
          st_data  = pd;
          st_mask  = pm;
        end
        tick();
        mem_ack  = 1'b0;
        st_valid = 1'b0;
        mcount--;
        if (acc) begin
          sbq.push_back('{addr: pa, data: pd, mask: pm});
          mcount++;
        end
        chk("drain_count", 32'(count), 32'(mcount));
        chk("drain_req_drop", 32'(mem_write_req), 32'd0);
      end
    end
  endtask

  initial begin
    int waited;
    logic [31:0] d;

    // Reset state
    repeat (2) tick();
    RESET = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_req", 32'(mem_write_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_data", mem_data, 32'd0);
    chk("rst_mem_mask", 32'(mem_mask), 32'd0);
    chk("rst_ld_hit", 32'(ld_hit), 32'd0);
    chk("rst_ld_stall", 32'(ld_stall), 32'd0);

    // Single store, ack two cycles after the request appears
    push(32'h100, 32'hDEADBEEF, 4'hF);
    chk("single_not_empty", 32'(empty), 32'd0);
    drain(2, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("single_empty", 32'(empty), 32'd1);

    // Youngest full-mask match forwards
    push(32'h200, 32'h11111111, 4'hF);
    push(32'h200, 32'h22222222, 4'hF);
    ld_valid = 1'b1;
    ld_addr  = 32'h200;
    #1;
    chk("fwd_hit", 32'(ld_hit), 32'd1);
    chk("fwd_data", ld_data, 32'h22222222);
    chk("fwd_stall", 32'(ld_stall), 32'd0);
    ld_addr = 32'h202;
    #1;
    chk("fwd_byteoff_data", ld_data, 32'h22222222);
    ld_addr = 32'h204;
    #1;
    chk("fwd_miss_hit", 32'(ld_hit), 32'd0);
    chk("fwd_miss_data", ld_data, 32'h0);
    ld_valid = 1'b0;
    drain(0, 1'b0, 32'h0, 32'h0, 4'h0);
    drain(0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Partial-mask match stalls until drained
    push(32'h300, 32'h33333333, 4'b0011);
    ld_valid = 1'b1;
    ld_addr  = 32'h300;
    #1;
    chk("partial_stall", 32'(ld_stall), 32'd1);
    chk("partial_hit", 32'(ld_hit), 32'd0);
    drain(1, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("partial_stall_clear", 32'(ld_stall), 32'd0);
    chk("partial_hit_clear", 32'(ld_hit), 32'd0);
    ld_valid = 1'b0;

    // Same-cycle push is invisible to the load; visible next cycle
    st_valid = 1'b1;
    st_addr  = 32'h400;
    st_data  = 32'h44444444;
    st_mask  = 4'hF;
    ld_valid = 1'b1;
    ld_addr  = 32'h400;
    #1;
    chk("samecyc_hit", 32'(ld_hit), 32'd0);
    tick();
    st_valid = 1'b0;
    sbq.push_back('{addr: 32'h400, data: 32'h44444444, mask: 4'hF});
    mcount++;
    chk("nextcyc_hit", 32'(ld_hit), 32'd1);
    chk("nextcyc_data", ld_data, 32'h44444444);
    ld_valid = 1'b0;
    drain(0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Fill to DEPTH across pointer wrap, reject overflow, then drain in order
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      push(32'h500 + 32'(4 * i), d, 4'hF);
    end
    chk("full_st_ready", 32'(st_ready), 32'd0);
    push(32'h5F0, 32'hBAD0BAD0, 4'hF);
    drain(0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("after_pop_st_ready", 32'(st_ready), 32'd1);
    drain(0, 1'b1, 32'h600, 32'h66666666, 4'hF);
    while (sbq.size() > 0) drain(0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("drained_empty", 32'(empty), 32'd1);

    // Reset while BUSY with a concurrent ack
    push(32'h700, 32'h77777777, 4'hF);
    waited = 0;
    while (mem_write_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("busy_before_reset", 32'(mem_write_req), 32'd1);
    RESET   = 1'b1;
    mem_ack = 1'b1;
    tick();
    RESET   = 1'b0;
    mem_ack = 1'b0;
    sbq.delete();
    mcount = 0;
    chk("busyrst_count", 32'(count), 32'd0);
    chk("busyrst_req", 32'(mem_write_req), 32'd0);
    chk("busyrst_empty", 32'(empty), 32'd1);
    chk("busyrst_st_ready", 32'(st_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busyrst_no_write", 32'(mem_write_req), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
